// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - DEPTH x WIDTH register file with busy scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_param #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [WIDTH-1:0]  data_writeReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [WIDTH-1:0]  data_readRegA,
   output logic [WIDTH-1:0]  data_readRegB,
   input  logic              ctrl_markBusy,
   input  logic [ADDR_W-1:0] ctrl_busyReg,
   output logic              busy_A,
   output logic              busy_B
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic             wr_hit;
   logic             mark_hit;

   // r0 is a hardwired zero, so neither port may touch it
   assign wr_hit   = ctrl_writeEnable && (ctrl_writeReg != '0);
   assign mark_hit = ctrl_markBusy && (ctrl_busyReg != '0);

   // Register storage; r0 is never written and keeps its cleared value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[ctrl_writeReg] <= data_writeReg;
      end
   end

   // Next busy vector: write-back clears, then issue sets, so a new producer wins
   always_comb begin
      busy_next = busy;
      if (wr_hit) begin
         busy_next[ctrl_writeReg] = 1'b0;
      end
      if (mark_hit) begin
         busy_next[ctrl_busyReg] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Busy scoreboard register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Read port A: registered state, optionally overridden by the in-flight write
   always_comb begin
      data_readRegA = (ctrl_readRegA == '0) ? '0 : regs[ctrl_readRegA];
      busy_A        = (ctrl_readRegA != '0) && busy[ctrl_readRegA];
`ifdef REGFILE_BYPASS_EN
      // forwarding is suppressed while reset holds the file cleared
      if (reset && wr_hit && (ctrl_writeReg == ctrl_readRegA)) begin
         data_readRegA = data_writeReg;
         busy_A        = mark_hit && (ctrl_busyReg == ctrl_readRegA);
      end
`endif
   end

   // Read port B: same lookup as port A on its own address
   always_comb begin
      data_readRegB = (ctrl_readRegB == '0) ? '0 : regs[ctrl_readRegB];
      busy_B        = (ctrl_readRegB != '0) && busy[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
      if (reset && wr_hit && (ctrl_writeReg == ctrl_readRegB)) begin
         data_readRegB = data_writeReg;
         busy_B        = mark_hit && (ctrl_busyReg == ctrl_readRegB);
      end
`endif
   end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard testbench for regfile_param
module tb_regfile_param;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              clock;
   logic              reset;
   logic              ctrl_writeEnable;
   logic [ADDR_W-1:0] ctrl_writeReg;
   logic [WIDTH-1:0]  data_writeReg;
   logic [ADDR_W-1:0] ctrl_readRegA;
   logic [ADDR_W-1:0] ctrl_readRegB;
   logic [WIDTH-1:0]  data_readRegA;
   logic [WIDTH-1:0]  data_readRegB;
   logic              ctrl_markBusy;
   logic [ADDR_W-1:0] ctrl_busyReg;
   logic              busy_A;
   logic              busy_B;

   regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock            (clock),
      .reset            (reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .ctrl_markBusy    (ctrl_markBusy),
      .ctrl_busyReg     (ctrl_busyReg),
      .busy_A           (busy_A),
      .busy_B           (busy_B)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [WIDTH-1:0] da;
      logic [WIDTH-1:0] db;
      logic             ba;
      logic             bb;
      string            nm;
   } exp_t;

   exp_t sq[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: a plain array of values and a set of busy flags
   logic [WIDTH-1:0] m_val [DEPTH];
   bit               m_busy [DEPTH];

   function automatic bool_fwd(input logic [ADDR_W-1:0] a);
   endfunction

   function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
      return reset && ctrl_writeEnable && (ctrl_writeReg != 0) && (ctrl_writeReg == a);
`else
      return 1'b0 && (a == 0);
`endif
   endfunction

   function automatic logic [WIDTH-1:0] exp_data(input logic [ADDR_W-1:0] a);
      if (a == 0) return '0;
      if (fwd_hit(a)) return data_writeReg;
      return m_val[a];
   endfunction

   function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
      if (a == 0) return 1'b0;
      if (fwd_hit(a)) return ctrl_markBusy && (ctrl_busyReg == a);
      return m_busy[a];
   endfunction

   task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // monitor: outputs are stable mid-cycle, one expectation per cycle
   always @(negedge clock) begin
      if (sq.size() > 0) begin
         exp_t e;
         e = sq.pop_front();
         check({e.nm, " dataA"}, data_readRegA, e.da);
         check({e.nm, " dataB"}, data_readRegB, e.db);
         check({e.nm, " busyA"}, {31'b0, busy_A}, {31'b0, e.ba});
         check({e.nm, " busyB"}, {31'b0, busy_B}, {31'b0, e.bb});
      end
   end

   // one cycle: drive inputs, queue the expected reads, then advance the model across the edge
   task automatic step(input bit rst, input bit we, input int wreg, input logic [WIDTH-1:0] wdata,
                       input int ra, input int rb, input bit mark, input int breg, input string nm);
      exp_t e;
      reset            = rst;
      ctrl_writeEnable = we;
      ctrl_writeReg    = ADDR_W'(wreg);
      data_writeReg    = wdata;
      ctrl_readRegA    = ADDR_W'(ra);
      ctrl_readRegB    = ADDR_W'(rb);
      ctrl_markBusy    = mark;
      ctrl_busyReg     = ADDR_W'(breg);
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
         end
      end
      e.da = exp_data(ctrl_readRegA);
      e.db = exp_data(ctrl_readRegB);
      e.ba = exp_busy(ctrl_readRegA);
      e.bb = exp_busy(ctrl_readRegB);
      e.nm = nm;
      sq.push_back(e);
      @(posedge clock);
      if (rst) begin
         if (we && wreg != 0) begin
            m_val[wreg]  = wdata;
            m_busy[wreg] = 1'b0;
         end
         if (mark && breg != 0) m_busy[breg] = 1'b1;
      end
      #1;
   endtask

   initial begin
      reset            = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      ctrl_readRegA    = '0;
      ctrl_readRegB    = '0;
      ctrl_markBusy    = 1'b0;
      ctrl_busyReg     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         m_val[i]  = '0;
         m_busy[i] = 1'b0;
      end
      @(posedge clock);
      #1;

      // reset held with random activity on every input
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, int'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), 1'b1, int'($urandom_range(0, 31)), "in_reset");
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 0, '0, i * 8 + 1, 31 - i * 8, 1'b0, 0, "post_reset");
      end

      // basic write/read and r0 protection
      step(1'b1, 1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0, "wr_r5");
      step(1'b1, 1'b0, 0, '0, 5, 5, 1'b0, 0, "rd_r5");
      step(1'b1, 1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b0, 0, "wr_r0");
      step(1'b1, 1'b0, 0, '0, 0, 0, 1'b0, 0, "rd_r0");

      // fill and sweep for aliasing
      for (int i = 1; i < DEPTH; i++) begin
         step(1'b1, 1'b1, i, 32'(i) * 32'h01010101, 0, 0, 1'b0, 0, "fill");
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 0, '0, i, DEPTH - 1 - i, 1'b0, 0, "sweep");
      end

      // scoreboard directed cases
      step(1'b1, 1'b0, 0, '0, 7, 0, 1'b1, 7, "mark_r7");
      step(1'b1, 1'b1, 7, 32'h1234, 7, 7, 1'b0, 0, "wb_r7");
      step(1'b1, 1'b0, 0, '0, 7, 7, 1'b0, 0, "after_wb_r7");
      step(1'b1, 1'b1, 9, 32'h9999, 9, 0, 1'b1, 9, "mark_wr_r9");
      step(1'b1, 1'b0, 0, '0, 9, 9, 1'b0, 0, "after_r9");
      step(1'b1, 1'b1, 11, 32'hBBBB, 10, 11, 1'b1, 10, "mark10_wr11");
      step(1'b1, 1'b1, 11, 32'hCCCC, 10, 11, 1'b1, 10, "remark10_wr11");
      step(1'b1, 1'b0, 0, '0, 10, 11, 1'b0, 0, "after_10_11");
      step(1'b1, 1'b0, 0, '0, 0, 0, 1'b1, 0, "mark_r0");
      step(1'b1, 1'b0, 0, '0, 0, 9, 1'b0, 0, "after_mark_r0");

      // asynchronous reset between edges with a write pending
      step(1'b1, 1'b1, 3, 32'hA5A5A5A5, 0, 0, 1'b1, 3, "wr_mark_r3");
      step(1'b1, 1'b0, 0, '0, 3, 3, 1'b0, 0, "r3_before_rst");
      step(1'b0, 1'b1, 3, 32'h11111111, 3, 3, 1'b0, 0, "rst_mid_wr_r3");
      step(1'b1, 1'b0, 0, '0, 3, 3, 1'b0, 0, "r3_after_rst");

      // read during write on r12
      step(1'b1, 1'b1, 12, 32'h12121212, 0, 0, 1'b0, 0, "wr_r12_old");
      step(1'b1, 1'b1, 12, 32'h55AA55AA, 12, 12, 1'b0, 0, "rdw_r12");
      step(1'b1, 1'b0, 0, '0, 12, 12, 1'b0, 0, "after_rdw_r12");

      // random traffic; narrow address range to provoke collisions
      for (int i = 0; i < 300; i++) begin
         int hi;
         hi = (i < 150) ? 7 : 31;
         step(1'b1, 1'($urandom), int'($urandom_range(0, hi)), $urandom,
              int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
              1'($urandom), int'($urandom_range(0, hi)), "random");
      end

      ctrl_writeEnable = 1'b0;
      ctrl_markBusy    = 1'b0;
      for (int i = 0; i < 10 && sq.size() > 0; i++) begin
         @(posedge clock);
      end
      total++;
      if (sq.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", sq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
